pim_cmd_issuer: RTL and testbench

- Bus-side master for the PIM peripheral: drives the 32-bit address/data command bus that the peripheral decodes, and samples its 32-bit readback word.
- Accepts commands from the RISC-V core side through a valid/ready queue.
- Serialises commands onto the peripheral bus with correct idle spacing.
- Captures read data after a fixed latency.
- Optionally polls a status register until a PIM operation completes, then returns a response.

---
 rtl/pim_cmd_issuer_if.sv | 32 +++
 rtl/pim_cmd_issuer.sv | 189 ++++++++++++++++++
 tb/tb_pim_cmd_issuer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_cmd_issuer_if.sv
// Command/response queue and PIM peripheral bus signals for pim_cmd_issuer.
// The slave modport is the issuer's view; master is the core/peripheral side.
interface pim_cmd_issuer_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        cmd_rd_i;
    logic        cmd_poll_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic [31:0] address_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        busy_o;

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_rd_i, cmd_poll_i,
        input  rsp_ready_i, data_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output address_o, data_o, busy_o
    );

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_rd_i, cmd_poll_i,
        output rsp_ready_i, data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  address_o, data_o, busy_o
    );
endinterface

// File: rtl/pim_cmd_issuer.sv
// Bus-side master for the PIM peripheral: queues core commands, issues them on the
// address/data bus with idle spacing, captures read data and optionally polls status.
module pim_cmd_issuer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned READ_LAT    = 2,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0F00,
    parameter int unsigned POLL_GAP    = 4,
    parameter int unsigned MAX_POLLS   = 255
) (
    input logic             clk_i,
    input logic             rst_ni,
    pim_cmd_issuer_if.slave bus
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LatMax = (READ_LAT > POLL_GAP) ? READ_LAT : POLL_GAP;
    localparam int unsigned CntW   = $clog2(LatMax + 1);
    localparam int unsigned PollW  = $clog2(MAX_POLLS + 1);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        poll;
    } cmd_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StRsp,
        StGap,
        StPollIssue,
        StPollWait
    } state_e;

    cmd_t            r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [PtrW:0]   r_count;
    logic            r_rdy_en;

    state_e          r_state;
    cmd_t            r_cmd;
    logic [CntW-1:0] r_cnt;
    logic [PollW-1:0] r_polls;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_err;

    logic            w_full;
    logic            w_empty;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    cmd_t            w_push_cmd;

    assign w_full     = (r_count == FullCount);
    assign w_empty    = (r_count == '0);
    // Ready stays low until the first clock after reset release.
    assign w_ready    = r_rdy_en & ~w_full;
    assign w_push     = bus.cmd_valid_i & w_ready;
    assign w_pop      = (r_state == StIdle) & ~w_empty;
    assign w_push_cmd = '{addr: bus.cmd_addr_i, data: bus.cmd_data_i,
                          rd: bus.cmd_rd_i, poll: bus.cmd_poll_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= w_push_cmd;
    end

    // Bus outputs default to idle; only the ISSUE/POLL_ISSUE states drive them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_cmd       <= '0;
            r_cnt       <= '0;
            r_polls     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_addr <= '0;
            r_data <= '0;
            unique case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_cmd   <= r_mem[r_rptr];
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    r_addr <= r_cmd.addr;
                    r_data <= r_cmd.data;
                    if (r_cmd.rd) begin
                        r_cnt   <= CntW'(READ_LAT);
                        r_state <= StWaitRd;
                    end else if (r_cmd.poll) begin
                        r_cnt   <= CntW'(POLL_GAP);
                        r_polls <= '0;
                        r_state <= StGap;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StWaitRd: begin
                    if (r_cnt == CntW'(1)) begin
                        r_rsp_data  <= bus.data_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRsp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StRsp: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                StGap: begin
                    if (r_cnt == CntW'(1)) begin
                        r_state <= StPollIssue;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StPollIssue: begin
                    r_addr  <= STATUS_ADDR;
                    r_data  <= '0;
                    r_polls <= r_polls + 1'b1;
                    r_cnt   <= CntW'(READ_LAT);
                    r_state <= StPollWait;
                end
                StPollWait: begin
                    if (r_cnt != CntW'(1)) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!bus.data_i[0]) begin
                        r_rsp_data  <= bus.data_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRsp;
                    end else if (r_polls < PollW'(MAX_POLLS)) begin
                        r_cnt   <= CntW'(POLL_GAP);
                        r_state <= StGap;
                    end else begin
                        r_rsp_data  <= bus.data_i;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRsp;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready_o = w_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_data_o  = r_rsp_data;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.address_o   = r_addr;
    assign bus.data_o      = r_data;
    assign bus.busy_o      = (r_state != StIdle) | ~w_empty;

endmodule

// File: tb/tb_pim_cmd_issuer.sv
// Scoreboard bench for pim_cmd_issuer: directed commands push expectations into queues,
// a negedge monitor pops and compares bus issues and responses.
module tb_pim_cmd_issuer;
    localparam int unsigned ReadLat  = 2;
    localparam int unsigned PollGap  = 4;
    localparam int unsigned MaxPolls = 3;
    localparam logic [31:0] StatAddr = 32'h0000_0F00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pim_cmd_issuer_if bus ();

    pim_cmd_issuer #(
        .FIFO_DEPTH (4),
        .READ_LAT   (ReadLat),
        .STATUS_ADDR(StatAddr),
        .POLL_GAP   (PollGap),
        .MAX_POLLS  (MaxPolls)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {logic [31:0] a; logic [31:0] d;} bus_t;
    typedef struct {logic [31:0] d; logic e;} rsp_t;
    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    bus_t mon_b;
    rsp_t mon_r;

    int n_cmp = 0;
    int n_err = 0;
    int n_issue = 0;

    // Peripheral model: one pipeline stage gives data READ_LAT=2 cycles after the address.
    logic [31:0] pipe_q;
    int unsigned stat_cnt = 0;
    int unsigned stat_base = 0;
    int unsigned busy_polls = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= bus.address_o;
            if (bus.address_o == StatAddr) stat_cnt <= stat_cnt + 1;
        end
    end

    always_comb begin
        bus.data_i = 32'h0;
        if (pipe_q == StatAddr) begin
            bus.data_i = ((stat_cnt - stat_base) <= busy_polls) ? 32'h1 : 32'h0;
        end else if (pipe_q == 32'h20) begin
            bus.data_i = 32'hDEAD_BEEF;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) bus.cmd_valid_i |-> bus.cmd_addr_i != 0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor
    logic [31:0] prev_addr = '0;
    int          idle_run = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        hold_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_addr = '0;
            idle_run  = 0;
            hold_v    = 1'b0;
        end else begin
            if (bus.address_o != 0) begin
                n_issue++;
                check("issue_separation", {32'h0, prev_addr}, 64'h0);
                check("no_issue_during_rsp", {63'h0, bus.rsp_valid_o}, 64'h0);
                if (bus.address_o == StatAddr)
                    check("poll_gap_idle", {63'h0, idle_run >= int'(PollGap)}, 64'h1);
                if (exp_bus.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_issue: got addr %h data %h want none",
                             bus.address_o, bus.data_o);
                end else begin
                    mon_b = exp_bus.pop_front();
                    check("bus_issue", {bus.address_o, bus.data_o}, {mon_b.a, mon_b.d});
                end
                idle_run = 0;
            end else begin
                check("idle_data_zero", {32'h0, bus.data_o}, 64'h0);
                idle_run++;
            end
            prev_addr = bus.address_o;

            if (bus.rsp_valid_o) begin
                if (hold_v)
                    check("rsp_stable", {31'h0, bus.rsp_err_o, bus.rsp_data_o},
                          {31'h0, hold_e, hold_d});
                if (bus.rsp_ready_i) begin
                    hold_v = 1'b0;
                    if (exp_rsp.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_rsp: got data %h err %b want none",
                                 bus.rsp_data_o, bus.rsp_err_o);
                    end else begin
                        mon_r = exp_rsp.pop_front();
                        check("rsp", {31'h0, bus.rsp_err_o, bus.rsp_data_o},
                              {31'h0, mon_r.e, mon_r.d});
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_d = bus.rsp_data_o;
                    hold_e = bus.rsp_err_o;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic poll);
        bit acc = 1'b0;
        bus.cmd_addr_i  = a;
        bus.cmd_data_i  = d;
        bus.cmd_rd_i    = rd;
        bus.cmd_poll_i  = poll;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = bus.cmd_ready_o;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid_i = 1'b0;
        if (acc) begin
            exp_bus.push_back('{a: a, d: d});
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got ready 0 want accept of addr %h", a);
        end
    endtask

    task automatic wait_drain(input string name);
        int i = 0;
        while ((bus.busy_o || bus.rsp_valid_o || exp_bus.size() != 0 || exp_rsp.size() != 0)
               && i < 2000) begin
            @(posedge clk);
            #1;
            i++;
        end
        check({name, "_drain"}, {63'h0, i < 2000}, 64'h1);
    endtask

    task automatic push_status(input int n);
        for (int i = 0; i < n; i++) exp_bus.push_back('{a: StatAddr, d: 32'h0});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        int issues0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_data_i  = '0;
        bus.cmd_rd_i    = 1'b0;
        bus.cmd_poll_i  = 1'b0;
        bus.rsp_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_address", {32'h0, bus.address_o}, 64'h0);
        check("rst_data", {32'h0, bus.data_o}, 64'h0);
        check("rst_rsp", {30'h0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o}, 64'h0);
        check("rst_ready_busy", {62'h0, bus.cmd_ready_o, bus.busy_o}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", {63'h0, bus.cmd_ready_o}, 64'h1);

        // Back-to-back writes
        send(32'h10, 32'hA, 1'b0, 1'b0);
        send(32'h14, 32'hB, 1'b0, 1'b0);
        send(32'h18, 32'hC, 1'b0, 1'b0);
        check("first_issue_timing", {bus.address_o, bus.data_o}, {32'h10, 32'hA});
        check("busy_during_writes", {63'h0, bus.busy_o}, 64'h1);
        i = 0;
        while (bus.address_o != 32'h18 && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("last_write_seen", {63'h0, i < 20}, 64'h1);
        @(posedge clk);
        #1;
        check("busy_after_writes", {63'h0, bus.busy_o}, 64'h0);
        wait_drain("writes");

        // Read with backpressure, then fill the queue behind the pending response
        bus.rsp_ready_i = 1'b0;
        exp_rsp.push_back('{d: 32'hDEAD_BEEF, e: 1'b0});
        send(32'h20, 32'h0, 1'b1, 1'b0);
        i = 0;
        while (!bus.rsp_valid_o && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("rd_rsp_arrives", {63'h0, bus.rsp_valid_o}, 64'h1);
        for (int k = 0; k < 4; k++) send(32'h50 + 32'(4 * k), 32'h100 + 32'(k), 1'b0, 1'b0);
        check("queue_full", {63'h0, bus.cmd_ready_o}, 64'h0);
        bus.cmd_addr_i  = 32'h60;
        bus.cmd_data_i  = 32'h999;
        bus.cmd_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("fifth_blocked", {63'h0, bus.cmd_ready_o}, 64'h0);
            check("bus_idle_in_rsp", {32'h0, bus.address_o}, 64'h0);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid_i = 1'b0;
        check("rsp_held", {31'h0, bus.rsp_valid_o, bus.rsp_data_o}, {31'h0, 1'b1, 32'hDEAD_BEEF});
        check("rsp_held_err", {63'h0, bus.rsp_err_o}, 64'h0);
        bus.rsp_ready_i = 1'b1;
        wait_drain("read_fill");

        // Poll completes on the third status read
        busy_polls = 2;
        stat_base  = stat_cnt;
        exp_rsp.push_back('{d: 32'h0, e: 1'b0});
        send(32'h30, 32'h77, 1'b0, 1'b1);
        push_status(3);
        wait_drain("poll_done");
        check("poll_done_count", {32'h0, stat_cnt - stat_base}, 64'd3);

        // Poll times out after MaxPolls status reads
        busy_polls = 1000;
        stat_base  = stat_cnt;
        exp_rsp.push_back('{d: 32'h1, e: 1'b1});
        send(32'h34, 32'h88, 1'b0, 1'b1);
        push_status(3);
        wait_drain("poll_timeout");
        check("poll_timeout_count", {32'h0, stat_cnt - stat_base}, 64'd3);

        // Reset during WAIT_RD with two commands queued
        exp_rsp.push_back('{d: 32'h0, e: 1'b0});
        send(32'h40, 32'h0, 1'b1, 1'b0);
        send(32'h44, 32'h1, 1'b0, 1'b0);
        send(32'h48, 32'h2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_bus.delete();
        exp_rsp.delete();
        check("mid_rst_bus", {bus.address_o, bus.data_o}, 64'h0);
        check("mid_rst_rsp", {30'h0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o}, 64'h0);
        check("mid_rst_ready_busy", {62'h0, bus.cmd_ready_o, bus.busy_o}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        issues0 = n_issue;
        @(posedge clk);
        #1;
        check("ready_after_mid_rst", {63'h0, bus.cmd_ready_o}, 64'h1);
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_issue", {32'h0, 32'(n_issue - issues0)}, 64'h0);
        check("queue_empty_after_rst", {62'h0, bus.busy_o, bus.rsp_valid_o}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
